// File: rtl/mp_add_pkg.sv
// Shared types and widths for the sequential multi-precision adder.
// The zero field exists only when MP_ADD_ZERO_EN is defined.
package mp_add_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned MAX_WORDS = 16;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] sum;
        logic              last;
        logic              cout;
        logic              ovf;
`ifdef MP_ADD_ZERO_EN
        logic              zero;
`endif
    } out_entry_t;

endpackage

// File: rtl/mp_add_slice.sv
// Combinational word adder: {cout, sum} = a + b + cin.
module mp_add_slice
    import mp_add_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_c_o,
    output logic              cout_c_o
);

    assign {cout_c_o, sum_c_o} = (WORD_W+1)'(a_i) + (WORD_W+1)'(b_i) + (WORD_W+1)'(cin_i);

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision adder, LS word first, with carry chained across beats.
// Define MP_ADD_ZERO_EN to add the out_zero result flag.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              cin,
    input  logic              in_abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf
`ifdef MP_ADD_ZERO_EN
    ,
    output logic              out_zero
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              valid_q, valid_d;
    out_entry_t        buf_q, buf_d;
`ifdef MP_ADD_ZERO_EN
    logic              zflag_q, zflag_d;
`endif

    logic              accept_c;
    logic              is_last_c;
    logic              add_cin_c;
    logic [WORD_W-1:0] add_sum_c;
    logic              add_cout_c;

    mp_add_slice u_slice (
        .a_i      (in_a),
        .b_i      (in_b),
        .cin_i    (add_cin_c),
        .sum_c_o  (add_sum_c),
        .cout_c_o (add_cout_c)
    );

    assign accept_c  = in_valid && in_ready;
    assign is_last_c = (cnt_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (in_abort) begin
            state_d = IDLE;
        end else if (accept_c) begin
            state_d = is_last_c ? IDLE : RUN;
        end
    end

    // State-dependent outputs: handshake and adder carry-in select
    always_comb begin
        in_ready  = !in_abort && (!valid_q || out_ready);
        add_cin_c = (state_q == IDLE) ? cin : carry_q;
    end

    // Datapath next values; a new word may replace one draining this cycle
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        valid_d = valid_q;
        buf_d   = buf_q;
`ifdef MP_ADD_ZERO_EN
        zflag_d = zflag_q;
`endif
        if (out_ready) begin
            valid_d = 1'b0;
        end
        if (in_abort) begin
            cnt_d   = '0;
            carry_d = 1'b0;
`ifdef MP_ADD_ZERO_EN
            zflag_d = 1'b1;
`endif
        end else if (accept_c) begin
            valid_d    = 1'b1;
            buf_d.sum  = add_sum_c;
            buf_d.last = is_last_c;
            if (is_last_c) begin
                cnt_d      = '0;
                carry_d    = 1'b0;
                buf_d.cout = add_cout_c;
                buf_d.ovf  = (in_a[WORD_W-1] == in_b[WORD_W-1]) &&
                             (add_sum_c[WORD_W-1] != in_a[WORD_W-1]);
`ifdef MP_ADD_ZERO_EN
                buf_d.zero = zflag_q && (add_sum_c == '0) && !add_cout_c;
                zflag_d    = 1'b1;
`endif
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = add_cout_c;
`ifdef MP_ADD_ZERO_EN
                if (add_sum_c != '0) begin
                    zflag_d = 1'b0;
                end
`endif
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            buf_q   <= '0;
`ifdef MP_ADD_ZERO_EN
            zflag_q <= 1'b1;
`endif
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
`ifdef MP_ADD_ZERO_EN
            zflag_q <= zflag_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = buf_q.sum;
    assign out_last  = buf_q.last;
    assign out_cout  = buf_q.cout;
    assign out_ovf   = buf_q.ovf;
`ifdef MP_ADD_ZERO_EN
    assign out_zero  = buf_q.zero;
`endif

endmodule
